// File: rtl/multi_dev_bridge.sv
// CPU-to-device bridge: decodes a 16-byte window per device, runs one access at a time
// through IDLE/ACCESS/RESP with a bounded ack wait, and registers the device interrupt lines.
module multi_dev_bridge #(
  parameter int unsigned NDEV    = 4,
  parameter logic [27:0] BASE_HI = 28'h00007F0,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 PrReq,
  input  logic [31:0]          PrAddr,
  input  logic [31:0]          PrWD,
  input  logic                 WeCPU,
  output logic [31:0]          PrRD,
  output logic                 PrReady,
  output logic                 PrErr,
  output logic [31:0]          DEV_Addr,
  output logic [31:0]          DEV_WD,
  output logic                 DEV_We,
  output logic [NDEV-1:0]      DEV_Sel,
  input  logic [32*NDEV-1:0]   DEV_RD,
  input  logic [NDEV-1:0]      DEV_Ack,
  input  logic [NDEV-1:0]      DEV_Irq,
  output logic [NDEV-1:0]      IrqOut
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       rd_q, rd_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wd_q, wd_d;
  logic              we_q, we_d;
  logic [NDEV-1:0]   sel_q, sel_d;
  logic [NDEV-1:0]   irq_q;

  logic [NDEV-1:0]   hit_sel;
  logic              ack_sel;
  logic [31:0]       rd_sel;

  always_comb begin
    hit_sel = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (PrAddr[31:4] == BASE_HI + 28'(i)) hit_sel[i] = 1'b1;
    end
  end

  // Only the selected device's ack and data matter; others are masked by sel_q.
  always_comb begin
    ack_sel = |(DEV_Ack & sel_q);
    rd_sel  = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      if (sel_q[i]) rd_sel = DEV_RD[32*i +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wd_d    = wd_q;
    we_d    = we_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (PrReq) begin
          addr_d = PrAddr;
          wd_d   = PrWD;
          we_d   = WeCPU;
          if (|hit_sel) begin
            sel_d   = hit_sel;
            cnt_d   = '0;
            state_d = ACCESS;
          end else begin
            rdy_d   = 1'b1;
            err_d   = 1'b1;
            rd_d    = '0;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (ack_sel) begin
          rdy_d   = 1'b1;
          rd_d    = we_q ? 32'h0 : rd_sel;
          sel_d   = '0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdy_d   = 1'b1;
          err_d   = 1'b1;
          rd_d    = '0;
          sel_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        sel_d   = '0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      irq_q   <= DEV_Irq;
    end
  end

  assign PrRD     = rd_q;
  assign PrReady  = rdy_q;
  assign PrErr    = err_q;
  assign DEV_Addr = addr_q;
  assign DEV_WD   = wd_q;
  assign DEV_We   = we_q;
  assign DEV_Sel  = sel_q;
  assign IrqOut   = irq_q;

endmodule

// File: tb/tb_multi_dev_bridge.sv
// Directed, table-driven bench for multi_dev_bridge with default parameters.
module tb_multi_dev_bridge;

  localparam int NDEV = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                PrReq;
  logic [31:0]         PrAddr;
  logic [31:0]         PrWD;
  logic                WeCPU;
  logic [31:0]         PrRD;
  logic                PrReady;
  logic                PrErr;
  logic [31:0]         DEV_Addr;
  logic [31:0]         DEV_WD;
  logic                DEV_We;
  logic [NDEV-1:0]     DEV_Sel;
  logic [32*NDEV-1:0]  DEV_RD;
  logic [NDEV-1:0]     DEV_Ack;
  logic [NDEV-1:0]     DEV_Irq;
  logic [NDEV-1:0]     IrqOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_dev_bridge #(
    .NDEV    (NDEV),
    .BASE_HI (28'h00007F0),
    .TIMEOUT (8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .PrReq    (PrReq),
    .PrAddr   (PrAddr),
    .PrWD     (PrWD),
    .WeCPU    (WeCPU),
    .PrRD     (PrRD),
    .PrReady  (PrReady),
    .PrErr    (PrErr),
    .DEV_Addr (DEV_Addr),
    .DEV_WD   (DEV_WD),
    .DEV_We   (DEV_We),
    .DEV_Sel  (DEV_Sel),
    .DEV_RD   (DEV_RD),
    .DEV_Ack  (DEV_Ack),
    .DEV_Irq  (DEV_Irq),
    .IrqOut   (IrqOut)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        we;
    int          dev;      // slice that returns rd, -1 for none
    logic [31:0] rd;
    int          ack_cyc;  // ACCESS cycle (1-based) in which the selected device acks, 0 = never
    logic [3:0]  stray;    // unselected acks asserted on odd cycles
    logic [3:0]  exp_sel;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Entered and left at posedge+1 with the DUT idle.
  task automatic run_txn(input vec_t v, input int idx);
    int          lat;
    logic        got_err;
    logic [31:0] got_rd;
    logic [3:0]  resp_sel;
    logic [31:0] resp_addr;
    logic        hold_ok;
    lat = 0; got_err = 1'b0; got_rd = '0; resp_sel = '0; resp_addr = '0; hold_ok = 1'b1;
    for (int i = 0; i < NDEV; i++) DEV_RD[32*i +: 32] = 32'hEEEE_0000 | 32'(i);
    if (v.dev >= 0) DEV_RD[32*v.dev +: 32] = v.rd;
    PrReq = 1'b1; PrAddr = v.addr; PrWD = v.wd; WeCPU = v.we; DEV_Ack = '0;
    @(posedge clk); #1;
    PrReq = 1'b0; PrAddr = ~v.addr; PrWD = ~v.wd; WeCPU = ~v.we;
    for (int c = 1; c <= 40; c++) begin
      DEV_Ack = ((v.ack_cyc == c) ? v.exp_sel : 4'b0) | ((c % 2 == 1) ? v.stray : 4'b0);
      @(negedge clk);
      if (PrReady) begin
        lat = c; got_err = PrErr; got_rd = PrRD; resp_sel = DEV_Sel; resp_addr = DEV_Addr;
        break;
      end
      if (DEV_Sel !== v.exp_sel || DEV_Addr !== v.addr || DEV_WD !== v.wd ||
          DEV_We !== v.we || PrErr !== 1'b0) hold_ok = 1'b0;
      @(posedge clk); #1;
    end
    DEV_Ack = '0;
    chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
    chk($sformatf("v%0d PrErr", idx), {31'b0, got_err}, {31'b0, v.exp_err});
    chk($sformatf("v%0d PrRD", idx), got_rd, v.exp_rd);
    chk($sformatf("v%0d Sel in RESP", idx), {28'b0, resp_sel}, 32'h0);
    chk($sformatf("v%0d DEV_Addr", idx), resp_addr, v.addr);
    if (v.exp_lat > 1) chk($sformatf("v%0d hold", idx), {31'b0, hold_ok}, 32'h1);
    @(negedge clk);
    chk($sformatf("v%0d pulse end", idx), {30'b0, PrReady, PrErr}, 32'h0);
    chk($sformatf("v%0d PrRD hold", idx), PrRD, v.exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen;
    logic [5:0] pat;

    vecs[0] = '{32'h00007F14, 32'h0,        1'b0,  1, 32'hCAFE0001, 1, 4'b0000, 4'b0010, 2, 1'b0, 32'hCAFE0001};
    vecs[1] = '{32'h00007F30, 32'h12345678, 1'b1,  3, 32'hFFFFFFFF, 4, 4'b0000, 4'b1000, 5, 1'b0, 32'h0};
    vecs[2] = '{32'h00007F40, 32'h0,        1'b0, -1, 32'h0,        0, 4'b0000, 4'b0000, 1, 1'b1, 32'h0};
    vecs[3] = '{32'h00007F0C, 32'h0,        1'b0,  0, 32'hA5A50000, 2, 4'b0000, 4'b0001, 3, 1'b0, 32'hA5A50000};
    vecs[4] = '{32'h00007F28, 32'h0,        1'b0,  2, 32'h11112222, 0, 4'b0001, 4'b0100, 9, 1'b1, 32'h0};
    vecs[5] = '{32'h00007F2F, 32'h0,        1'b0,  2, 32'h0BADF00D, 8, 4'b0001, 4'b0100, 9, 1'b0, 32'h0BADF00D};
    vecs[6] = '{32'h00007EFC, 32'hAAAA5555, 1'b1, -1, 32'h0,        0, 4'b0000, 4'b0000, 1, 1'b1, 32'h0};
    vecs[7] = '{32'h10007F14, 32'h0,        1'b0, -1, 32'h0,        0, 4'b0010, 4'b0000, 1, 1'b1, 32'h0};
    vecs[8] = '{32'h00007F3C, 32'h0,        1'b0,  3, 32'hDEADBEEF, 1, 4'b0100, 4'b1000, 2, 1'b0, 32'hDEADBEEF};

    reset_n = 1'b0; PrReq = 1'b0; PrAddr = '0; PrWD = '0; WeCPU = 1'b0;
    DEV_RD = '0; DEV_Ack = '0; DEV_Irq = 4'b1010;
    @(negedge clk);
    chk("reset PrRD/Ready/Err", {PrRD[29:0], PrReady, PrErr}, 32'h0);
    chk("reset DEV_Addr", DEV_Addr, 32'h0);
    chk("reset DEV_WD", DEV_WD, 32'h0);
    chk("reset Sel/We/Irq", {23'b0, DEV_Sel, DEV_We, IrqOut}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    DEV_Irq = 4'b0000;

    foreach (vecs[i]) run_txn(vecs[i], i);

    // Interrupt path: one-cycle delay, independent of access state.
    DEV_Irq = 4'b1111;
    @(posedge clk); #1;
    DEV_Irq = 4'b0101;
    @(negedge clk);
    chk("IrqOut before edge", {28'b0, IrqOut}, 32'hF);
    @(posedge clk); #1;
    chk("IrqOut after edge", {28'b0, IrqOut}, 32'h5);

    // Reset during ACCESS aborts the access with no later PrReady.
    PrReq = 1'b1; PrAddr = 32'h00007F14; PrWD = 32'h55; WeCPU = 1'b1; DEV_Ack = '0;
    @(posedge clk); #1;
    PrReq = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset Sel", {28'b0, DEV_Sel}, 32'h2);
    reset_n = 1'b0;
    #1;
    chk("async rst PrRD", PrRD, 32'h0);
    chk("async rst DEV_Addr", DEV_Addr, 32'h0);
    chk("async rst DEV_WD", DEV_WD, 32'h0);
    chk("async rst misc", {24'b0, DEV_Sel, DEV_We, PrReady, PrErr, 1'b0}, 32'h0);
    chk("async rst IrqOut", {28'b0, IrqOut}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    DEV_Ack = 4'b0010;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (PrReady) seen = 1'b1;
    end
    @(posedge clk); #1;
    DEV_Ack = '0;
    chk("no ready after reset", {31'b0, seen}, 32'h0);
    run_txn(vecs[0], 100);

    // Back-to-back hits with PrReq held: one access per three cycles.
    PrReq = 1'b1; PrAddr = 32'h00007F04; WeCPU = 1'b0; DEV_Ack = 4'b0001;
    DEV_RD[31:0] = 32'h13579BDF;
    pat = '0;
    @(posedge clk); #1;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) PrReq = 1'b0;
      @(negedge clk);
      pat[c-1] = PrReady;
      @(posedge clk); #1;
    end
    DEV_Ack = '0;
    chk("back-to-back pattern", {26'b0, pat}, 32'h12);
    chk("back-to-back PrRD", PrRD, 32'h13579BDF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
